// File: rtl/scanline_reader.sv
// ============================================================================
// Module      : scanline_reader
// Description : Streams ping-pong scanline banks to a timed pixel output and
//               requests the next line from the renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scanline_reader #(
    parameter int H_ACTIVE      = 320,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 48,
    parameter int H_BP          = 16,
    parameter int V_ACTIVE      = 240,
    parameter int V_FP          = 4,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 16,
    parameter int CLEAR_ON_READ = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] ram_addr_o,
    output logic       ram_we_o,
    output logic [7:0] ram_d_o,
    input  logic [7:0] ram_q_i,
    output logic [7:0] pix_o,
    output logic       de_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       line_req_o,
    output logic [9:0] line_num_o,
    output logic       line_bank_o
);

    localparam logic [10:0] c_h_active   = 11'(H_ACTIVE);
    localparam logic [10:0] c_h_total    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] c_hs_start   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_v_active   = 11'(V_ACTIVE);
    localparam logic [10:0] c_v_total    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] c_vs_start   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_end     = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_act1;
    logic       r_hs1;
    logic       r_vs1;

    logic       w_h_last;
    logic       w_v_last;
    logic [9:0] w_v_next;
    logic       w_active;
    logic       w_hs;
    logic       w_vs;

    assign w_h_last = ({1'b0, r_h_cnt} == c_h_total - 11'd1);
    assign w_v_last = ({1'b0, r_v_cnt} == c_v_total - 11'd1);
    assign w_v_next = w_v_last ? 10'd0 : r_v_cnt + 10'd1;
    assign w_active = ({1'b0, r_h_cnt} < c_h_active) && ({1'b0, r_v_cnt} < c_v_active);
    assign w_hs     = ({1'b0, r_h_cnt} >= c_hs_start) && ({1'b0, r_h_cnt} < c_hs_end);
    assign w_vs     = ({1'b0, r_v_cnt} >= c_vs_start) && ({1'b0, r_v_cnt} < c_vs_end);

    // Bank select is the line parity, so line n always lives in bank n[0].
    assign ram_addr_o = {r_v_cnt[0], r_h_cnt[8:0]};
    assign ram_d_o    = 8'h00;

    generate
        if (CLEAR_ON_READ != 0) begin : g_clear
            assign ram_we_o = w_active & ~rst;
        end else begin : g_no_clear
            assign ram_we_o = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (w_h_last) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= w_v_next;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Stage 1 lines up timing flags with the RAM read latency; stage 2 registers outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act1  <= 1'b0;
            r_hs1   <= 1'b0;
            r_vs1   <= 1'b0;
            pix_o   <= 8'h00;
            de_o    <= 1'b0;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
        end else begin
            r_act1  <= w_active;
            r_hs1   <= w_hs;
            r_vs1   <= w_vs;
            pix_o   <= r_act1 ? ram_q_i : 8'h00;
            de_o    <= r_act1;
            hsync_o <= ~r_hs1;
            vsync_o <= ~r_vs1;
        end
    end

    // Request the following line at the start of each line; number and bank hold between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_req_o  <= 1'b0;
            line_num_o  <= 10'd0;
            line_bank_o <= 1'b0;
        end else if ((r_h_cnt == 10'd0) && ({1'b0, w_v_next} < c_v_active)) begin
            line_req_o  <= 1'b1;
            line_num_o  <= w_v_next;
            line_bank_o <= w_v_next[0];
        end else begin
            line_req_o  <= 1'b0;
        end
    end

endmodule

`default_nettype wire
